// File: rtl/mem_req_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_queue
//  Purpose  : Request FIFO and single-outstanding issue controller that feeds
//             mem_system. Requests come in over a valid/ready handshake. The
//             controller issues one request at a time and holds
//             Addr/DataIn/Rd/Wr until Done. It then returns a one-cycle
//             registered response, updates saturating hit/miss counters and
//             keeps a sticky miss-latency watchdog flag.
//  Ports    : clk, rst (sync, active-low)
//             req_valid/req_ready/req_wr/req_addr/req_data   requester side
//             Addr/DataIn/Rd/Wr -> mem_system
//             Stall/Done/CacheHit/DataOut <- mem_system
//             rsp_valid/rsp_wr/rsp_addr/rsp_data/rsp_hit      response
//             hit_count/miss_count/timeout_err                status
//  Revision : 1.0  initial release
// ============================================================================
module mem_req_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_LAT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic [15:0] Addr,
    output logic [15:0] DataIn,
    output logic        Rd,
    output logic        Wr,
    input  logic        Stall,
    input  logic        Done,
    input  logic        CacheHit,
    input  logic [15:0] DataOut,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [15:0] rsp_addr,
    output logic [15:0] rsp_data,
    output logic        rsp_hit,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
    output logic        timeout_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_LW = $clog2(MAX_LAT + 1);
    localparam logic [c_LW-1:0] c_LAT_MAX  = c_LW'(MAX_LAT);
    localparam logic [c_LW-1:0] c_LAT_TRIP = c_LW'(MAX_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_issue;
    logic   w_finish;

    // FIFO entry layout: [31] wr, [30:16] addr[15:1], [15:0] data.
    // Address bit 0 is never stored since Addr always drives it low.
    logic [31:0]     r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [31:0]     w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_unused_addr0;

    logic [15:0]     r_addr;
    logic [15:0]     r_din;
    logic            r_rd;
    logic            r_wr;
    logic [c_LW-1:0] r_lat;
    logic            r_timeout;
    logic            r_rsp_valid;
    logic            r_rsp_wr;
    logic [15:0]     r_rsp_addr;
    logic [15:0]     r_rsp_data;
    logic            r_rsp_hit;
    logic [15:0]     r_hit;
    logic [15:0]     r_miss;

    assign w_unused_addr0 = req_addr[0];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_push  = req_valid && !w_full;
    assign w_head  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= {req_wr, req_addr[15:1], req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue is only considered in IDLE. The cycle right after Done is
    // therefore always an IDLE cycle with strobes low: this is the bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !Stall) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_lat       <= '0;
            r_timeout   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_hit       <= '0;
            r_miss      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;

            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end

            if (w_issue) begin
                r_rptr <= r_rptr + c_PW'(1);
                r_addr <= {w_head[30:16], 1'b0};
                r_din  <= w_head[15:0];
                r_rd   <= ~w_head[31];
                r_wr   <= w_head[31];
                r_lat  <= '0;
            end

            // The flag rises on the same edge at which lat_cnt reaches
            // MAX_LAT. The request keeps waiting; nothing is aborted.
            if ((r_state == S_WAIT) && !Done) begin
                if (r_lat != c_LAT_MAX) begin
                    r_lat <= r_lat + c_LW'(1);
                end
                if (r_lat == c_LAT_TRIP) begin
                    r_timeout <= 1'b1;
                end
            end

            if (w_finish) begin
                r_rd        <= 1'b0;
                r_wr        <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_wr    <= r_wr;
                r_rsp_addr  <= r_addr;
                r_rsp_data  <= r_rd ? DataOut : 16'h0000;
                r_rsp_hit   <= CacheHit;
                if (CacheHit) begin
                    if (r_hit != 16'hFFFF) begin
                        r_hit <= r_hit + 16'd1;
                    end
                end else begin
                    if (r_miss != 16'hFFFF) begin
                        r_miss <= r_miss + 16'd1;
                    end
                end
            end
        end
    end

    assign req_ready   = !w_full;
    assign Addr        = r_addr;
    assign DataIn      = r_din;
    assign Rd          = r_rd;
    assign Wr          = r_wr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_wr      = r_rsp_wr;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_data    = r_rsp_data;
    assign rsp_hit     = r_rsp_hit;
    assign hit_count   = r_hit;
    assign miss_count  = r_miss;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
